// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - port bundle linking pipeline, arbiter and unified memory
// Width macros default here so the bundle builds standalone.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

interface mem_port_arbiter_if;
    logic                    i_instr_req_en;
    logic [`ADDR_W-1:0]      i_instr_req_addr;
    logic                    o_instr_stall;
    logic                    o_instr_res_valid;
    logic [`WORD_W-1:0]      o_instr_res_data;
    logic [`ADDR_W-1:0]      i_data_req_addr;
    logic [`WORD_W-1:0]      i_data_req_wr_data;
    logic                    i_data_req_wr_en;
    logic [`MEM_COUNT_W-1:0] i_data_req_count;
    logic                    o_data_stall;
    logic                    o_data_res_valid;
    logic [`WORD_W-1:0]      o_data_res_rd_data;
    logic [`MEM_CODE_W-1:0]  o_data_res_code;
    logic                    o_mem_req_en;
    logic [`ADDR_W-1:0]      o_mem_req_addr;
    logic [`WORD_W-1:0]      o_mem_req_wr_data;
    logic                    o_mem_req_wr_en;
    logic [`MEM_COUNT_W-1:0] o_mem_req_count;
    logic [`WORD_W-1:0]      i_mem_res_rd_data;
    logic [`MEM_CODE_W-1:0]  i_mem_res_code;
    logic [1:0]              owner;

    modport slave (
        input  i_instr_req_en, i_instr_req_addr,
        input  i_data_req_addr, i_data_req_wr_data, i_data_req_wr_en, i_data_req_count,
        input  i_mem_res_rd_data, i_mem_res_code,
        output o_instr_stall, o_instr_res_valid, o_instr_res_data,
        output o_data_stall, o_data_res_valid, o_data_res_rd_data, o_data_res_code,
        output o_mem_req_en, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_en, o_mem_req_count,
        output owner
    );

    modport master (
        output i_instr_req_en, i_instr_req_addr,
        output i_data_req_addr, i_data_req_wr_data, i_data_req_wr_en, i_data_req_count,
        output i_mem_res_rd_data, i_mem_res_code,
        input  o_instr_stall, o_instr_res_valid, o_instr_res_data,
        input  o_data_stall, o_data_res_valid, o_data_res_rd_data, o_data_res_code,
        input  o_mem_req_en, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_en, o_mem_req_count,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
// Optional starvation guard for the fetch port: define ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              clr,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_DATA  = 2'd1,
        OWN_INSTR = 2'd2
    } owner_t;

    localparam int CW = `MEM_COUNT_W;
    localparam logic [CW-1:0] WORD_BYTES = CW'(`WORD_W / 8);
    // An out-of-range latency or starvation limit leaves the arbiter inert.
    localparam logic CFG_OK = (RD_LAT >= 1) && (RD_LAT <= 4) && (STARVE_MAX >= 1);

    logic active;
    logic data_req;
    logic instr_req;
    logic force_instr;
    logic grant_data;
    logic grant_instr;
    logic read_grant;
    owner_t owner;
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_instr;
    logic tail_valid;
    logic instr_hit;
    logic data_hit;

    assign active      = !clr && CFG_OK;
    assign data_req    = active && (bus.i_data_req_count != '0);
    assign instr_req   = active && bus.i_instr_req_en;
    assign grant_data  = data_req && !force_instr;
    assign grant_instr = instr_req && !grant_data;
    assign read_grant  = grant_instr || (grant_data && !bus.i_data_req_wr_en);

    assign bus.o_instr_stall = instr_req && !grant_instr;

`ifdef ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign force_instr      = instr_req && (starve_cnt == SW'(STARVE_MAX));
    assign bus.o_data_stall = data_req && !grant_data;

    always_ff @(posedge clk) begin
        if (clr) begin
            starve_cnt <= '0;
        end else if (!instr_req || grant_instr) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_instr      = 1'b0;
    assign bus.o_data_stall = 1'b0;
`endif

    always_comb begin
        bus.o_mem_req_en      = grant_data || grant_instr;
        bus.o_mem_req_addr    = '0;
        bus.o_mem_req_wr_data = '0;
        bus.o_mem_req_wr_en   = 1'b0;
        bus.o_mem_req_count   = '0;
        if (grant_data) begin
            bus.o_mem_req_addr    = bus.i_data_req_addr;
            bus.o_mem_req_wr_data = bus.i_data_req_wr_data;
            bus.o_mem_req_wr_en   = bus.i_data_req_wr_en;
            bus.o_mem_req_count   = bus.i_data_req_count;
        end else if (grant_instr) begin
            bus.o_mem_req_addr  = bus.i_instr_req_addr;
            bus.o_mem_req_count = WORD_BYTES;
        end
    end

    // Tag pipe: slot 0 is this cycle's grant, the last slot lines up with memory read data.
    always_ff @(posedge clk) begin
        if (clr) begin
            tag_valid <= '0;
            tag_instr <= '0;
        end else begin
            tag_valid[0] <= read_grant;
            tag_instr[0] <= grant_instr;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_instr[i] <= tag_instr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            owner <= OWN_IDLE;
        end else if (grant_data) begin
            owner <= OWN_DATA;
        end else if (grant_instr) begin
            owner <= OWN_INSTR;
        end else begin
            owner <= OWN_IDLE;
        end
    end

    assign bus.owner = owner;

    assign tail_valid = tag_valid[RD_LAT-1] && !clr;
    assign instr_hit  = tail_valid && tag_instr[RD_LAT-1];
    assign data_hit   = tail_valid && !tag_instr[RD_LAT-1];

    assign bus.o_instr_res_valid  = instr_hit;
    assign bus.o_instr_res_data   = instr_hit ? bus.i_mem_res_rd_data : '0;
    assign bus.o_data_res_valid   = data_hit;
    assign bus.o_data_res_rd_data = data_hit ? bus.i_mem_res_rd_data : '0;
    assign bus.o_data_res_code    = data_hit ? bus.i_mem_res_code : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(3)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    // Memory model: returns 0xF0000000|addr and code addr[3:2] two cycles after any access.
    logic              m_en0 = 1'b0;
    logic              m_en1 = 1'b0;
    logic [`ADDR_W-1:0] m_a0 = '0;
    logic [`ADDR_W-1:0] m_a1 = '0;

    always @(posedge clk) begin
        m_en0 <= bus.o_mem_req_en;
        m_a0  <= bus.o_mem_req_addr;
        m_en1 <= m_en0;
        m_a1  <= m_a0;
    end

    assign bus.i_mem_res_rd_data = m_en1 ? (32'hF000_0000 | m_a1) : '0;
    assign bus.i_mem_res_code    = m_en1 ? m_a1[3:2] : '0;

    typedef struct {
        logic                    clr;
        logic                    ien;
        logic [`ADDR_W-1:0]      iaddr;
        logic [`ADDR_W-1:0]      daddr;
        logic [`WORD_W-1:0]      wdata;
        logic                    wen;
        logic [`MEM_COUNT_W-1:0] cnt;
        logic                    istall;
        logic                    dstall;
        logic                    men;
        logic [`ADDR_W-1:0]      maddr;
        logic [`WORD_W-1:0]      mwdata;
        logic                    mwen;
        logic [`MEM_COUNT_W-1:0] mcnt;
        logic                    iv;
        logic [`WORD_W-1:0]      idata;
        logic                    dv;
        logic [`WORD_W-1:0]      ddata;
        logic [`MEM_CODE_W-1:0]  code;
        logic [1:0]              owner;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic ien, input logic [31:0] iaddr,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input logic wen, input logic [3:0] cnt);
        clr                    = c;
        bus.i_instr_req_en     = ien;
        bus.i_instr_req_addr   = iaddr;
        bus.i_data_req_addr    = daddr;
        bus.i_data_req_wr_data = wdata;
        bus.i_data_req_wr_en   = wen;
        bus.i_data_req_count   = cnt;
    endtask

    initial begin
        //          clr ien iaddr  daddr     wdata          wen cnt  ist dst men maddr    mwdata         mwen mcnt iv idata           dv ddata           code own
        vecs[0]  = '{1, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   0};
        vecs[1]  = '{1, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   0};
        vecs[2]  = '{1, 1, 'h40,  'h80,     'h55,          0,  4,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   0};
        vecs[3]  = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   0};
        vecs[4]  = '{0, 1, 'h0,   'h0,      'h0,           0,  0,   0,  0,  1,  'h0,     'h0,           0,   4,   0, 'h0,            0, 'h0,            0,   0};
        vecs[5]  = '{0, 1, 'h4,   'h0,      'h0,           0,  0,   0,  0,  1,  'h4,     'h0,           0,   4,   0, 'h0,            0, 'h0,            0,   2};
        vecs[6]  = '{0, 1, 'h8,   'h0,      'h0,           0,  0,   0,  0,  1,  'h8,     'h0,           0,   4,   1, 'hF0000000,     0, 'h0,            0,   2};
        vecs[7]  = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   1, 'hF0000004,     0, 'h0,            0,   2};
        vecs[8]  = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   1, 'hF0000008,     0, 'h0,            0,   0};
        vecs[9]  = '{0, 1, 'h10,  'h100,    'h0,           0,  4,   1,  0,  1,  'h100,   'h0,           0,   4,   0, 'h0,            0, 'h0,            0,   0};
        vecs[10] = '{0, 1, 'h10,  'h0,      'h0,           0,  0,   0,  0,  1,  'h10,    'h0,           0,   4,   0, 'h0,            0, 'h0,            0,   1};
        vecs[11] = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            1, 'hF0000100,     0,   2};
        vecs[12] = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   1, 'hF0000010,     0, 'h0,            0,   0};
        vecs[13] = '{0, 0, 'h0,   'h200,    'hDEADBEEF,    1,  4,   0,  0,  1,  'h200,   'hDEADBEEF,    1,   4,   0, 'h0,            0, 'h0,            0,   0};
        vecs[14] = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   1};
        vecs[15] = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   0};
        vecs[16] = '{0, 0, 'h0,   'h10C,    'h0,           0,  2,   0,  0,  1,  'h10C,   'h0,           0,   2,   0, 'h0,            0, 'h0,            0,   0};
        vecs[17] = '{1, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   1};
        vecs[18] = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   0};
        vecs[19] = '{0, 0, 'h0,   'h10C,    'h0,           0,  2,   0,  0,  1,  'h10C,   'h0,           0,   2,   0, 'h0,            0, 'h0,            0,   0};
        vecs[20] = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            0, 'h0,            0,   1};
        vecs[21] = '{0, 0, 'h0,   'h0,      'h0,           0,  0,   0,  0,  0,  'h0,     'h0,           0,   0,   0, 'h0,            1, 'hF000010C,     3,   0};

        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            cyc = i;
            drive(vecs[i].clr, vecs[i].ien, vecs[i].iaddr, vecs[i].daddr,
                  vecs[i].wdata, vecs[i].wen, vecs[i].cnt);
            #1;
            chk("instr_stall",   32'(bus.o_instr_stall),      32'(vecs[i].istall));
            chk("data_stall",    32'(bus.o_data_stall),       32'(vecs[i].dstall));
            chk("mem_req_en",    32'(bus.o_mem_req_en),       32'(vecs[i].men));
            chk("mem_req_addr",  32'(bus.o_mem_req_addr),     32'(vecs[i].maddr));
            chk("mem_wr_data",   32'(bus.o_mem_req_wr_data),  32'(vecs[i].mwdata));
            chk("mem_wr_en",     32'(bus.o_mem_req_wr_en),    32'(vecs[i].mwen));
            chk("mem_count",     32'(bus.o_mem_req_count),    32'(vecs[i].mcnt));
            chk("instr_valid",   32'(bus.o_instr_res_valid),  32'(vecs[i].iv));
            chk("instr_data",    32'(bus.o_instr_res_data),   32'(vecs[i].idata));
            chk("data_valid",    32'(bus.o_data_res_valid),   32'(vecs[i].dv));
            chk("data_rd_data",  32'(bus.o_data_res_rd_data), 32'(vecs[i].ddata));
            chk("data_code",     32'(bus.o_data_res_code),    32'(vecs[i].code));
            chk("owner",         32'(bus.owner),              32'(vecs[i].owner));
        end

        // Both ports request every cycle; fetch only wins when the starvation guard is built.
        for (int i = 0; i < 12; i++) begin
            logic exp_instr;
            @(negedge clk);
            cyc = 22 + i;
            drive(1'b0, 1'b1, 32'h20, 32'h300, 32'h0, 1'b0, 4'd4);
            #1;
`ifdef ARB_FAIRNESS_EN
            exp_instr = ((i % 4) == 3);
`else
            exp_instr = 1'b0;
`endif
            chk("fair_addr",        32'(bus.o_mem_req_addr), exp_instr ? 32'h20 : 32'h300);
            chk("fair_data_stall",  32'(bus.o_data_stall),   32'(exp_instr));
            chk("fair_instr_stall", 32'(bus.o_instr_stall),  32'(!exp_instr));
        end

        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        repeat (RD_LAT + 1) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
